// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: sequential radix-2 shift-add multiplier and restoring divider
// with a start/busy/done handshake, plus MTHI/MTLO writes while idle.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 b_zero_q, b_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dvz_q, dvz_d;

    logic                 sgn_op;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   mul_next, div_next;
    logic [WIDTH-1:0]     quo_mag, rem_mag;

    assign sgn_op = ~op_i[0];
    assign a_abs  = (sgn_op && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs  = (sgn_op && b_i[WIDTH-1]) ? -b_i : b_i;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Upper half is the partial remainder; the next dividend bit shifts in from the lower half.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign quo_mag = acc_q[WIDTH-1:0];
    assign rem_mag = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dvz_d     = dvz_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !op_i[2]) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    is_div_d  = op_i[1];
                    a_raw_d   = a_i;
                    b_zero_d  = (b_i == '0);
                    neg_d     = sgn_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    rem_neg_d = sgn_op & a_i[WIDTH-1];
                    dvz_d     = 1'b0;
                    if (op_i[1]) begin
                        opnd_d = b_abs;
                        acc_d  = {{WIDTH{1'b0}}, a_abs};
                    end else begin
                        opnd_d = a_abs;
                        acc_d  = {{WIDTH{1'b0}}, b_abs};
                    end
                end else if (start_i && op_i == 3'b100) begin
                    hi_d = a_i;
                end else if (start_i && op_i == 3'b101) begin
                    lo_d = a_i;
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end else if (b_zero_q) begin
                    hi_d  = a_raw_q;
                    lo_d  = '1;
                    dvz_d = 1'b1;
                end else begin
                    lo_d = neg_q ? -quo_mag : quo_mag;
                    hi_d = rem_neg_q ? -rem_mag : rem_mag;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dvz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dvz_q     <= dvz_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dvz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed 32-bit cases plus an 8-bit instance checked
// against an arithmetic reference model through a scoreboard queue.
module tb_hilo_muldiv_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned W8 = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [2:0]  op32 = '0, op8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy32, done32, dvz32, busy8, done8, dvz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    hilo_muldiv_unit #(.WIDTH(W)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
        .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32), .div_by_zero_o(dvz32)
    );

    hilo_muldiv_unit #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8), .div_by_zero_o(dvz8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dvz;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dvz);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dvz = dvz;
        scb.push_back(e);
    endtask

    function automatic exp_t model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int sa, sbv, ua, ub, p, q, r;
        sa = int'($signed(a)); sbv = int'($signed(b));
        ua = int'(a);          ub = int'(b);
        e.dvz = 1'b0;
        if (op == 3'b000 || op == 3'b001) begin
            p = (op == 3'b000) ? sa * sbv : ua * ub;
            e.hi = {24'b0, p[15:8]};
            e.lo = {24'b0, p[7:0]};
        end else if (b == 8'h00) begin
            e.hi = {24'b0, a}; e.lo = 32'h0000_00FF; e.dvz = 1'b1;
        end else begin
            q = (op == 3'b010) ? sa / sbv : ua / ub;
            r = (op == 3'b010) ? sa % sbv : ua % ub;
            e.hi = {24'b0, r[7:0]};
            e.lo = {24'b0, q[7:0]};
        end
        return e;
    endfunction

    // Drive one start pulse on the chosen instance; operands are scrambled after acceptance.
    task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (w8) begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin start32 = 1'b1; op32 = op; a32 = a; b32 = b; end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start8 = 1'b0; start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait_done(input bit w8, input string tag);
        int   n = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (n < 200 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = w8 ? done8 : done32;
        end
        check({tag, " done"}, 64'(seen), 64'd1);
        if (seen) check({tag, " latency"}, 64'(cyc - acc_cyc), 64'(w8 ? W8 + 1 : W + 1));
        if (scb.size() > 0) begin
            e = scb.pop_front();
            check({tag, " hi"},  w8 ? {56'b0, hi8} : {32'b0, hi32}, {32'b0, e.hi});
            check({tag, " lo"},  w8 ? {56'b0, lo8} : {32'b0, lo32}, {32'b0, e.lo});
            check({tag, " dvz"}, 64'(w8 ? dvz8 : dvz32), 64'(e.dvz));
            check({tag, " busy"}, 64'(w8 ? busy8 : busy32), 64'd0);
        end
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input string tag);
        exp_t e;
        e = model8(op, a, b);
        push(e.hi, e.lo, e.dvz);
        issue(1'b1, op, {24'b0, a}, {24'b0, b});
        wait_done(1'b1, tag);
    endtask

    initial begin
        #12;
        check("reset hi",   {32'b0, hi32}, 64'd0);
        check("reset lo",   {32'b0, lo32}, 64'd0);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset dvz",  64'(dvz32), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue(1'b0, 3'b000, 32'hFFFF_FFFD, 32'd7);
        check("mult busy", 64'(busy32), 64'd1);
        wait_done(1'b0, "mult");

        push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, "multu");

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(1'b0, 3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, "div neg");

        push(32'd1, 32'd3, 1'b0);
        issue(1'b0, 3'b011, 32'd7, 32'd2);
        wait_done(1'b0, "divu");

        push(32'd0, 32'h8000_0000, 1'b0);
        issue(1'b0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, "div ovf");

        push(32'd5, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 3'b011, 32'd5, 32'd0);
        wait_done(1'b0, "divu zero");

        push(32'd0, 32'd6, 1'b0);
        issue(1'b0, 3'b001, 32'd2, 32'd3);
        check("dvz clear", 64'(dvz32), 64'd0);
        check("hi stable", {32'b0, hi32}, 64'd5);
        wait_done(1'b0, "multu 2x3");

        @(negedge clk);
        start32 = 1'b1; op32 = 3'b100; a32 = 32'h0000_1234;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        check("mthi hi",   {32'b0, hi32}, 64'h1234);
        check("mthi lo",   {32'b0, lo32}, 64'd6);
        check("mthi busy", 64'(busy32), 64'd0);
        @(posedge clk);
        #1;
        check("mthi done", 64'(done32), 64'd0);

        push(32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0);
        issue(1'b0, 3'b000, 32'd10, 32'hFFFF_FFFE);
        @(negedge clk);
        start32 = 1'b1; op32 = 3'b101; a32 = 32'hDEAD_BEEF;
        @(negedge clk);
        op32 = 3'b000; a32 = 32'd3; b32 = 32'd3;
        @(negedge clk);
        op32 = 3'b100; a32 = 32'hCAFE_F00D;
        @(negedge clk);
        start32 = 1'b0;
        check("busy mt lo", {32'b0, lo32}, 64'd6);
        check("busy mt hi", {32'b0, hi32}, 64'h1234);
        wait_done(1'b0, "mult busy-ignore");

        // Start issued inside the done cycle must be accepted.
        push(32'd0, 32'd16, 1'b0);
        issue(1'b0, 3'b001, 32'd4, 32'd4);
        wait_done(1'b0, "start in done");

        issue(1'b0, 3'b001, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst hi",   {32'b0, hi32}, 64'd0);
        check("midrst lo",   {32'b0, lo32}, 64'd0);
        check("midrst busy", 64'(busy32), 64'd0);
        check("midrst done", 64'(done32), 64'd0);
        check("midrst dvz",  64'(dvz32), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        push(32'd0, 32'd15, 1'b0);
        issue(1'b0, 3'b001, 32'd3, 32'd5);
        wait_done(1'b0, "post-reset multu");

        run8(3'b000, 8'hFD, 8'h07, "w8 mult");
        run8(3'b001, 8'hFF, 8'hFF, "w8 multu");
        run8(3'b010, 8'hF9, 8'h02, "w8 div");
        run8(3'b011, 8'h07, 8'h02, "w8 divu");
        run8(3'b010, 8'h80, 8'hFF, "w8 div ovf");
        run8(3'b011, 8'h05, 8'h00, "w8 divu zero");
        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run8(op, a, b, "w8 rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
